// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared types and helpers for the reg_file register file.
//   - clr_state_t   : states of the bulk-clear engine
//   - MAX_LANES     : upper bound on byte lanes the mask helper supports
//   - lane_mask_bit : expands a byte-lane strobe into one bit of a bit mask
package reg_file_pkg;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    // Widest data word the mask helper can serve (128 lanes = 1024 bits).
    localparam int MAX_LANES = 128;

    // Bit bit_idx of the expanded mask is the strobe bit of the lane holding it.
    // The strobe arrives zero-extended to MAX_LANES so one function serves any WIDTH.
    function automatic logic lane_mask_bit(input logic [MAX_LANES-1:0] strb,
                                           input int                   bit_idx);
        logic r;
        r = 1'b0;
        for (int l = 0; l < MAX_LANES; l++) begin
            if (l == (bit_idx / 8)) r = strb[l];
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port
//   One combinational read port of reg_file.
//   Ports:
//     i_word    : stored word at i_raddr (don't care when out of range)
//     i_raddr   : read address
//     i_wr_acc  : a write is being accepted this cycle
//     i_waddr   : address of that write
//     i_wdata   : data of that write
//     i_mask    : expanded byte-lane mask of that write
//     o_rdata   : read data
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [WIDTH-1:0] i_word,
    input  logic [AW-1:0]    i_raddr,
    input  logic             i_wr_acc,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [WIDTH-1:0] i_mask,
    output logic [WIDTH-1:0] o_rdata
);

    always_comb begin
        o_rdata = i_word;
        // Forward the post-write value; only accepted writes ever reach here.
        if ((BYPASS != 0) && i_wr_acc && (i_waddr == i_raddr)) begin
            o_rdata = (i_wdata & i_mask) | (i_word & ~i_mask);
        end
        if (32'(i_raddr) >= DEPTH) begin
            o_rdata = '0;
        end
        if ((ZERO_REG != 0) && (i_raddr == '0)) begin
            o_rdata = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// reg_file
//   WIDTH x DEPTH register file: one byte-masked write port, two
//   combinational read ports, optional bypass, optional hardwired-zero
//   entry 0, and a sequential bulk-clear engine.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     i_we/i_waddr/i_wdata/i_wstrb : write port (wstrb bit i -> byte i)
//     i_raddr_a/o_rdata_a, i_raddr_b/o_rdata_b : read ports
//     i_clr_req      : one-cycle request to clear every entry
//     o_clr_busy     : high while the clear engine walks the array
//     o_clr_state    : debug view of the clear FSM state
//   Handshake: i_clr_req is taken only in CLR_IDLE; o_clr_busy stays high for
//   exactly DEPTH cycles and requests seen while busy are ignored. Writes are
//   dropped whenever o_clr_busy is high or i_clr_req is high.
module reg_file
    import reg_file_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic [WIDTH/8-1:0] i_wstrb,
    input  logic [AW-1:0]      i_raddr_a,
    output logic [WIDTH-1:0]   o_rdata_a,
    input  logic [AW-1:0]      i_raddr_b,
    output logic [WIDTH-1:0]   o_rdata_b,
    input  logic               i_clr_req,
    output logic               o_clr_busy,
    output clr_state_t         o_clr_state
);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    clr_state_t           r_state;
    logic [AW-1:0]        r_ptr;
    logic                 r_busy;

    logic [MAX_LANES-1:0] w_strb_ext;
    logic [WIDTH-1:0]     w_mask;
    logic                 w_wr_acc;

    assign w_strb_ext = MAX_LANES'(i_wstrb);

    for (genvar i = 0; i < WIDTH; i++) begin : g_mask
        assign w_mask[i] = lane_mask_bit(w_strb_ext, i);
    end

    // A pending clear request outranks a write in the same cycle.
    assign w_wr_acc = i_we && (r_state == CLR_IDLE) && !i_clr_req &&
                      (32'(i_waddr) < DEPTH) &&
                      !((ZERO_REG != 0) && (i_waddr == '0));

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mem[k] <= '0;
            end else if ((r_state == CLR_RUN) && (r_ptr == AW'(k))) begin
                r_mem[k] <= '0;
            end else if (w_wr_acc && (i_waddr == AW'(k))) begin
                r_mem[k] <= (i_wdata & w_mask) | (r_mem[k] & ~w_mask);
            end
        end
    end

    // Clear engine: one entry per cycle, returns to idle on the last entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLR_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                CLR_IDLE: begin
                    if (i_clr_req) begin
                        r_state <= CLR_RUN;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLR_RUN: begin
                    if (r_ptr == AW'(DEPTH - 1)) begin
                        r_state <= CLR_IDLE;
                        r_ptr   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= CLR_IDLE;
                    r_ptr   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_clr_busy  = r_busy;
    assign o_clr_state = r_state;

    reg_file_rd_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd_a (
        .i_word  (r_mem[i_raddr_a]),
        .i_raddr (i_raddr_a),
        .i_wr_acc(w_wr_acc),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .i_mask  (w_mask),
        .o_rdata (o_rdata_a)
    );

    reg_file_rd_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd_b (
        .i_word  (r_mem[i_raddr_b]),
        .i_raddr (i_raddr_b),
        .i_wr_acc(w_wr_acc),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .i_mask  (w_mask),
        .o_rdata (o_rdata_b)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file
//   Directed bench for reg_file: a default instance (32x32, ZERO_REG, BYPASS)
//   and a small 16x6 instance without ZERO_REG/BYPASS for out-of-range
//   addresses and non-bypassed reads.
module tb_reg_file;
    import reg_file_pkg::*;

    logic        clk;
    logic        rst_n;

    // Default instance
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  ra, rb;
    logic [31:0] rda, rdb;
    logic        clr_req;
    logic        busy;
    clr_state_t  state;

    // Small instance
    logic        s_we;
    logic [2:0]  s_waddr;
    logic [15:0] s_wdata;
    logic [1:0]  s_wstrb;
    logic [2:0]  s_ra, s_rb;
    logic [15:0] s_rda, s_rdb;
    logic        s_clr_req;
    logic        s_busy;
    clr_state_t  s_state;

    int checks;
    int failures;

    reg_file u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_wstrb(wstrb),
        .i_raddr_a(ra), .o_rdata_a(rda),
        .i_raddr_b(rb), .o_rdata_b(rdb),
        .i_clr_req(clr_req), .o_clr_busy(busy), .o_clr_state(state)
    );

    reg_file #(.WIDTH(16), .DEPTH(6), .ZERO_REG(0), .BYPASS(0)) u_small (
        .clk(clk), .rst_n(rst_n),
        .i_we(s_we), .i_waddr(s_waddr), .i_wdata(s_wdata), .i_wstrb(s_wstrb),
        .i_raddr_a(s_ra), .o_rdata_a(s_rda),
        .i_raddr_b(s_rb), .o_rdata_b(s_rdb),
        .i_clr_req(s_clr_req), .o_clr_busy(s_busy), .o_clr_state(s_state)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; reads are checked 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        we = 1'b1; waddr = a; wdata = d; wstrb = s;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        we = 0; waddr = 0; wdata = 0; wstrb = 0; ra = 0; rb = 0; clr_req = 0;
        s_we = 0; s_waddr = 0; s_wdata = 0; s_wstrb = 0; s_ra = 0; s_rb = 0; s_clr_req = 0;

        // ---- reset state ----
        #12;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_state", {31'b0, state}, {31'b0, CLR_IDLE});
        for (int a = 0; a < 32; a++) begin
            ra = 5'(a); rb = 5'(31 - a);
            #1;
            chk("rst_rd_a", rda, 32'h0);
            chk("rst_rd_b", rdb, 32'h0);
        end
        rst_n = 1'b1;
        step();

        // ---- full-word write, bypass then storage ----
        wr(5'd5, 32'hDEADBEEF, 4'hF); ra = 5'd5;
        #1 chk("wr5_bypass", rda, 32'hDEADBEEF);
        step(); we = 0;
        #1 chk("wr5_read", rda, 32'hDEADBEEF);

        // ---- byte-masked write ----
        wr(5'd3, 32'h11223344, 4'hF);
        step();
        wr(5'd3, 32'hAABBCCDD, 4'b0101); ra = 5'd3; rb = 5'd3;
        #1;
        chk("mask_bypass_a", rda, 32'h11BB33DD);
        chk("mask_bypass_b", rdb, 32'h11BB33DD);
        step(); we = 0;
        #1 chk("mask_read", rda, 32'h11BB33DD);

        // ---- wstrb=0 is a no-op ----
        wr(5'd5, 32'h12345678, 4'h0); ra = 5'd5;
        #1 chk("strb0_bypass", rda, 32'hDEADBEEF);
        step(); we = 0;
        #1 chk("strb0_read", rda, 32'hDEADBEEF);

        // ---- hardwired zero entry ----
        wr(5'd0, 32'hFFFFFFFF, 4'hF); ra = 5'd0; rb = 5'd0;
        #1 chk("zero_bypass", rda, 32'h0);
        step(); we = 0;
        #1;
        chk("zero_read_a", rda, 32'h0);
        chk("zero_read_b", rdb, 32'h0);

        // ---- small instance: no bypass, entry 0 writable, out of range ----
        s_we = 1; s_waddr = 3'd2; s_wdata = 16'hBEEF; s_wstrb = 2'b11; s_ra = 3'd2;
        #1 chk("s_nobypass", {16'h0, s_rda}, 32'h0);
        step();
        s_waddr = 3'd0; s_wdata = 16'h77A5; s_wstrb = 2'b01;
        #1 chk("s_rd2", {16'h0, s_rda}, 32'h0000BEEF);
        step();
        s_waddr = 3'd6; s_wdata = 16'h1234; s_wstrb = 2'b11;
        step(); s_we = 0;
        s_ra = 3'd0; s_rb = 3'd6;
        #1;
        chk("s_entry0", {16'h0, s_rda}, 32'h000000A5);
        chk("s_oor6", {16'h0, s_rdb}, 32'h0);
        s_rb = 3'd7;
        #1 chk("s_oor7", {16'h0, s_rdb}, 32'h0);
        for (int a = 1; a < 6; a++) begin
            s_ra = 3'(a);
            #1 chk("s_entries", {16'h0, s_rda}, (a == 2) ? 32'h0000BEEF : 32'h0);
        end

        // ---- clear: preload, request with concurrent write ----
        for (int a = 0; a < 32; a++) begin
            wr(5'(a), 32'hA5A5A5A5, 4'hF);
            step();
        end
        wr(5'd7, 32'h12345678, 4'hF); clr_req = 1'b1; ra = 5'd7;
        #1 chk("clr_req_nobypass", rda, 32'hA5A5A5A5);
        step();  // edge N
        we = 0; clr_req = 0;
        for (int c = 0; c < 32; c++) begin
            clr_req = (c == 10);
            we = (c == 3); waddr = 5'd2; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
            ra = (c == 3) ? 5'd2 : 5'd7;
            rb = 5'd20;
            #1;
            chk("clr_busy_high", {31'b0, busy}, 32'h1);
            if (c == 0) chk("clr_dropped_wr7", rda, 32'hA5A5A5A5);
            if (c == 3) begin
                chk("clr_mid_e2", rda, 32'h0);
                chk("clr_mid_e20", rdb, 32'hA5A5A5A5);
            end
            step();
        end
        we = 0; clr_req = 0;
        #1;
        chk("clr_done_busy", {31'b0, busy}, 32'h0);
        chk("clr_done_state", {31'b0, state}, {31'b0, CLR_IDLE});
        for (int a = 0; a < 32; a++) begin
            ra = 5'(a);
            #1 chk("clr_all_zero", rda, 32'h0);
        end
        // First accepted write right after the clear.
        wr(5'd9, 32'h0F0F0F0F, 4'hF);
        step(); we = 0; ra = 5'd9;
        #1 chk("post_clr_wr", rda, 32'h0F0F0F0F);
        step();
        chk("no_restart", {31'b0, busy}, 32'h0);

        // ---- reset aborts a clear mid-way ----
        wr(5'd30, 32'h5A5A5A5A, 4'hF);
        step(); we = 0;
        clr_req = 1'b1;
        step();  // edge N
        clr_req = 0;
        for (int c = 0; c < 15; c++) step();
        ra = 5'd30; rb = 5'd9;
        #1;
        chk("abort_pre_e30", rda, 32'h5A5A5A5A);
        chk("abort_pre_busy", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_state", {31'b0, state}, {31'b0, CLR_IDLE});
        chk("abort_e30", rda, 32'h0);
        chk("abort_e9", rdb, 32'h0);
        #20 rst_n = 1'b1;
        step();
        chk("abort_post_busy", {31'b0, busy}, 32'h0);
        wr(5'd11, 32'h00000001, 4'hF);
        step(); we = 0; ra = 5'd11; rb = 5'd30;
        #1;
        chk("post_rst_wr", rda, 32'h00000001);
        chk("post_rst_e30", rdb, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
